// File: rtl/mem_access_unit_pkg.sv
// Shared constants for the memory-access stage: funct3 encodings,
// error-cause codes, FSM states and request classification helpers.
package mem_access_unit_pkg;

  // Load encodings
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Store encodings
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'b00,
    ERR_MISALIGN = 2'b01,
    ERR_ILLEGAL  = 2'b10,
    ERR_TIMEOUT  = 2'b11
  } err_cause_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_BUSY = 2'b01,
    S_DONE = 2'b10
  } state_e;

  // Conflicting direction or an encoding outside the legal set for that direction.
  function automatic logic is_illegal(logic rd, logic wr, logic [2:0] f3);
    if (rd && wr) return 1'b1;
    if (wr) return !(f3 inside {F3_SB, F3_SH, F3_SW});
    return !(f3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU});
  endfunction

  // Size is encoded in funct3[1:0] for both loads and stores.
  function automatic logic is_misaligned(logic [2:0] f3, logic [1:0] addr_lo);
    case (f3[1:0])
      2'b01:   return addr_lo[0];
      2'b10:   return addr_lo != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Request/acknowledge data-memory bus shared by BRAM and MMIO targets.
interface mem_access_unit_if;
  logic        req;
  logic        we;
  logic [29:0] addr;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ack;

  modport master (output req, we, addr, be, wdata, input rdata, ack);
  modport slave  (input req, we, addr, be, wdata, output rdata, ack);
endinterface

// File: rtl/mem_access_unit_lsu_format.sv
// Combinational lane steering: store byte enables / replicated write data
// and load byte/half extraction with sign or zero extension.
module lsu_format
  import mem_access_unit_pkg::*;
(
  input  logic        is_store_i,
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] store_data_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] load_data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = rdata_i[{addr_lo_i, 3'b000} +: 8];
  assign half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];

  // Store lanes: loads always enable the full word.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned and infers a latch.
    be_o    = 4'b1111;
    wdata_o = store_data_i;
    if (is_store_i) begin
      case (funct3_i[1:0])
        2'b00: begin
          be_o    = 4'b0001 << addr_lo_i;
          wdata_o = {4{store_data_i[7:0]}};
        end
        2'b01: begin
          be_o    = 4'b0011 << addr_lo_i;
          wdata_o = {2{store_data_i[15:0]}};
        end
        default: ;
      endcase
    end
  end

  // Load extraction and extension.
  always_comb begin
    load_data_o = rdata_i;
    case (funct3_i)
      F3_LB:   load_data_o = {{24{byte_sel[7]}}, byte_sel};
      F3_LBU:  load_data_o = {24'h0, byte_sel};
      F3_LH:   load_data_o = {{16{half_sel[15]}}, half_sel};
      F3_LHU:  load_data_o = {16'h0, half_sel};
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Memory-access stage: classifies a load/store, runs it over the dmem bus
// with a timeout, and stalls the core until a one-cycle completion pulse.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] ALUResult,
  input  logic [31:0] ReadData2,
  input  logic [2:0]  funct3,
  output logic        stall_o,
  output logic        done_o,
  output logic [31:0] load_data_o,
  output logic        err_o,
  output logic [1:0]  err_cause_o,
  mem_access_unit_if.master dmem
);

  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e      state_q, state_d;
  err_cause_e  cause_q, cause_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic [2:0]  f3_q, f3_d;
  logic        we_q, we_d;
  logic [31:0] ld_q, ld_d;

  logic        start;
  logic        busy;
  logic [3:0]  fmt_be;
  logic [31:0] fmt_wdata;
  logic [31:0] fmt_load;

  // Gated by rst_n so stall_o is low while reset is held, whatever the controller drives.
  assign start = rst_n & (state_q == S_IDLE) & (MemRead | MemWrite);
  assign busy  = (state_q == S_BUSY);

  lsu_format u_fmt (
    .is_store_i   (we_q),
    .funct3_i     (f3_q),
    .addr_lo_i    (addr_q[1:0]),
    .store_data_i (data_q),
    .rdata_i      (dmem.rdata),
    .be_o         (fmt_be),
    .wdata_o      (fmt_wdata),
    .load_data_o  (fmt_load)
  );

  // State and latched-request registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cause_q <= ERR_NONE;
      cnt_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      f3_q    <= '0;
      we_q    <= 1'b0;
      ld_q    <= '0;
    end else begin
      // NOTE: non-blocking so every register samples the pre-edge values of the others.
      state_q <= state_d;
      cause_q <= cause_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      f3_q    <= f3_d;
      we_q    <= we_d;
      ld_q    <= ld_d;
    end
  end

  // Next-state: classify on start, wait for ack or timeout, then one DONE cycle.
  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    data_d  = data_q;
    f3_d    = f3_q;
    we_d    = we_q;
    ld_d    = ld_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          addr_d = ALUResult;
          data_d = ReadData2;
          f3_d   = funct3;
          we_d   = MemWrite;
          cnt_d  = '0;
          if (is_illegal(MemRead, MemWrite, funct3)) begin
            cause_d = ERR_ILLEGAL;
            state_d = S_DONE;
          end else if (is_misaligned(funct3, ALUResult[1:0])) begin
            cause_d = ERR_MISALIGN;
            state_d = S_DONE;
          end else begin
            cause_d = ERR_NONE;
            state_d = S_BUSY;
          end
        end
      end
      S_BUSY: begin
        // Ack takes priority over a coincident timeout.
        if (dmem.ack) begin
          if (!we_q) ld_d = fmt_load;
          state_d = S_DONE;
        end else if (cnt_q == CNT_LIMIT) begin
          cause_d = ERR_TIMEOUT;
          ld_d    = '0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign stall_o     = start | busy;
  assign done_o      = (state_q == S_DONE);
  assign err_o       = done_o & (cause_q != ERR_NONE);
  assign err_cause_o = done_o ? cause_q : ERR_NONE;
  assign load_data_o = ld_q;

  assign dmem.req   = busy;
  assign dmem.we    = busy & we_q;
  assign dmem.addr  = busy ? addr_q[31:2] : '0;
  assign dmem.be    = busy ? fmt_be : '0;
  assign dmem.wdata = busy ? fmt_wdata : '0;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench: each issued access pushes its expected outcome; a monitor
// pops and compares when done_o is seen. A responder models the memory.
module tb_mem_access_unit;
  import mem_access_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        MemRead = 1'b0;
  logic        MemWrite = 1'b0;
  logic [31:0] ALUResult = '0;
  logic [31:0] ReadData2 = '0;
  logic [2:0]  funct3 = '0;
  logic        stall_o;
  logic        done_o;
  logic [31:0] load_data_o;
  logic        err_o;
  logic [1:0]  err_cause_o;

  mem_access_unit_if dmem ();

  mem_access_unit #(.TIMEOUT_CYCLES(16), .CNT_W(5)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .MemRead     (MemRead),
    .MemWrite    (MemWrite),
    .ALUResult   (ALUResult),
    .ReadData2   (ReadData2),
    .funct3      (funct3),
    .stall_o     (stall_o),
    .done_o      (done_o),
    .load_data_o (load_data_o),
    .err_o       (err_o),
    .err_cause_o (err_cause_o),
    .dmem        (dmem)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [1:0]  cause;
    logic [31:0] ld;
    int          stalls;
    bit          req;
    logic        we;
    logic [29:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } exp_t;

  exp_t sb_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int cur_delay = -1;          // BUSY cycle index carrying ack; -1 = never
  logic [31:0] cur_rdata = '0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // Memory responder: ack raised for the BUSY cycle numbered cur_delay.
  initial begin : responder
    int k;
    k = 0;
    dmem.ack   = 1'b0;
    dmem.rdata = '0;
    forever begin
      @(negedge clk);
      dmem.rdata = cur_rdata;
      if (dmem.req === 1'b1) begin
        dmem.ack = (k == cur_delay);
        k++;
      end else begin
        dmem.ack = 1'b0;
        k = 0;
      end
    end
  end

  // Monitor: tracks stalls and bus activity, scores each completion.
  initial begin : monitor
    int stalls;
    bit req_seen, stable, prev_done;
    logic        m_we;
    logic [29:0] m_addr;
    logic [3:0]  m_be;
    logic [31:0] m_wdata;
    exp_t e;
    stalls = 0; req_seen = 0; stable = 1; prev_done = 0;
    m_we = 0; m_addr = '0; m_be = '0; m_wdata = '0;
    forever begin
      @(negedge clk or negedge rst_n);
      if (!rst_n) begin
        stalls = 0; req_seen = 0; stable = 1; prev_done = 0;
        continue;
      end
      if (stall_o) stalls++;
      if (dmem.req) begin
        if (!req_seen) begin
          req_seen = 1;
          m_we = dmem.we; m_addr = dmem.addr; m_be = dmem.be; m_wdata = dmem.wdata;
        end else if (m_we !== dmem.we || m_addr !== dmem.addr ||
                     m_be !== dmem.be || m_wdata !== dmem.wdata) begin
          stable = 0;
        end
      end
      if (done_o) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_done: got done_o=1, want no pending access");
        end else begin
          e = sb_q.pop_front();
          check({e.name, ".single_pulse"}, 32'(prev_done), 32'd0);
          check({e.name, ".cause"}, 32'(err_cause_o), 32'(e.cause));
          check({e.name, ".err"}, 32'(err_o), 32'(e.cause != 2'b00));
          check({e.name, ".load_data"}, load_data_o, e.ld);
          check({e.name, ".stalls"}, 32'(stalls), 32'(e.stalls));
          check({e.name, ".req_seen"}, 32'(req_seen), 32'(e.req));
          if (e.req) begin
            check({e.name, ".we"}, 32'(m_we), 32'(e.we));
            check({e.name, ".addr"}, 32'(m_addr), 32'(e.addr));
            check({e.name, ".be"}, 32'(m_be), 32'(e.be));
            check({e.name, ".stable"}, 32'(stable), 32'd1);
            if (e.we) check({e.name, ".wdata"}, m_wdata, e.wdata);
          end
        end
        stalls = 0; req_seen = 0; stable = 1;
      end
      prev_done = done_o;
    end
  end

  // Issue one access, push its expectation, hold it through DONE.
  task automatic run_op(string name, bit rd, bit wr, logic [2:0] f3,
                        logic [31:0] addr, logic [31:0] data, logic [31:0] rdata,
                        int delay, logic [1:0] cause, logic [31:0] ld, int stalls,
                        bit req, logic [3:0] be, logic [31:0] wdata);
    exp_t e;
    bit seen;
    e.name = name; e.cause = cause; e.ld = ld; e.stalls = stalls; e.req = req;
    e.we = wr; e.addr = addr[31:2]; e.be = be; e.wdata = wdata;
    sb_q.push_back(e);
    @(posedge clk); #1;
    cur_rdata = rdata;
    cur_delay = delay;
    MemRead = rd; MemWrite = wr; funct3 = f3; ALUResult = addr; ReadData2 = data;
    seen = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (done_o) begin
        seen = 1;
        break;
      end
    end
    check({name, ".done_seen"}, 32'(seen), 32'd1);
    @(posedge clk); #1;
    MemRead = 0; MemWrite = 0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    repeat (3) @(posedge clk);
    #1;
    check("reset.stall", 32'(stall_o), 32'd0);
    check("reset.done", 32'(done_o), 32'd0);
    check("reset.err", 32'(err_o), 32'd0);
    check("reset.cause", 32'(err_cause_o), 32'd0);
    check("reset.load_data", load_data_o, 32'h0);
    check("reset.req", 32'(dmem.req), 32'd0);
    rst_n = 1'b1;

    //      name    rd wr f3      addr          data          rdata         dly cause  ld            st req be       wdata
    run_op("sw",     0, 1, 3'b010, 32'h0000_1004, 32'hDEAD_BEEF, 32'h0,         2, 2'b00, 32'h0,         4, 1, 4'b1111, 32'hDEAD_BEEF);
    run_op("lb",     1, 0, 3'b000, 32'h0000_2003, 32'h0,         32'h80FF_1234, 0, 2'b00, 32'hFFFF_FF80, 2, 1, 4'b1111, 32'h0);
    run_op("lbu",    1, 0, 3'b100, 32'h0000_2003, 32'h0,         32'h80FF_1234, 0, 2'b00, 32'h0000_0080, 2, 1, 4'b1111, 32'h0);
    run_op("lh",     1, 0, 3'b001, 32'h0000_2002, 32'h0,         32'h80FF_1234, 0, 2'b00, 32'hFFFF_80FF, 2, 1, 4'b1111, 32'h0);
    run_op("lhu",    1, 0, 3'b101, 32'h0000_2002, 32'h0,         32'h80FF_1234, 0, 2'b00, 32'h0000_80FF, 2, 1, 4'b1111, 32'h0);
    run_op("lb_pos", 1, 0, 3'b000, 32'h0000_2001, 32'h0,         32'h80FF_1234, 0, 2'b00, 32'h0000_0012, 2, 1, 4'b1111, 32'h0);
    run_op("sh",     0, 1, 3'b001, 32'h0000_0006, 32'h0000_ABCD, 32'h0,         1, 2'b00, 32'h0000_0012, 3, 1, 4'b1100, 32'hABCD_ABCD);
    run_op("sb",     0, 1, 3'b000, 32'h0000_0003, 32'h0000_00A5, 32'h0,         0, 2'b00, 32'h0000_0012, 2, 1, 4'b1000, 32'hA5A5_A5A5);
    run_op("lw_mis", 1, 0, 3'b010, 32'h0000_0006, 32'h0,         32'h0,        -1, 2'b01, 32'h0000_0012, 1, 0, 4'b0000, 32'h0);
    run_op("sw_mis", 0, 1, 3'b010, 32'h0000_0002, 32'h1111_1111, 32'h0,        -1, 2'b01, 32'h0000_0012, 1, 0, 4'b0000, 32'h0);
    run_op("lh_mis", 1, 0, 3'b001, 32'h0000_2001, 32'h0,         32'h0,        -1, 2'b01, 32'h0000_0012, 1, 0, 4'b0000, 32'h0);
    run_op("lw_to",  1, 0, 3'b010, 32'h0000_0010, 32'h0,         32'h5555_5555,-1, 2'b11, 32'h0,        17, 1, 4'b1111, 32'h0);
    run_op("lw_ack16",1,0, 3'b010, 32'h0000_0014, 32'h0,         32'h1234_5678,15, 2'b00, 32'h1234_5678,17, 1, 4'b1111, 32'h0);
    run_op("rdwr",   1, 1, 3'b010, 32'h0000_0020, 32'h0,         32'h0,        -1, 2'b10, 32'h1234_5678, 1, 0, 4'b0000, 32'h0);
    run_op("ld_f011",1, 0, 3'b011, 32'h0000_0020, 32'h0,         32'h0,        -1, 2'b10, 32'h1234_5678, 1, 0, 4'b0000, 32'h0);
    run_op("st_f100",0, 1, 3'b100, 32'h0000_0020, 32'h0,         32'h0,        -1, 2'b10, 32'h1234_5678, 1, 0, 4'b0000, 32'h0);

    // Reset in the middle of a BUSY access: bus request and stall drop at once.
    @(posedge clk); #1;
    cur_delay = -1;
    MemRead = 1; MemWrite = 0; funct3 = 3'b010; ALUResult = 32'h0000_0040;
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_busy.req", 32'(dmem.req), 32'd0);
    check("rst_busy.stall", 32'(stall_o), 32'd0);
    check("rst_busy.done", 32'(done_o), 32'd0);
    check("rst_busy.load_data", load_data_o, 32'h0);
    MemRead = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;

    run_op("lw_post",1, 0, 3'b010, 32'h0000_0044, 32'h0,         32'hCAFE_F00D, 0, 2'b00, 32'hCAFE_F00D, 2, 1, 4'b1111, 32'h0);

    repeat (3) @(posedge clk);
    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
